// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the data-memory arbiter: core and debug request ports
// plus the single shared memory port. The arbiter sits on the slave
// modport; the environment (requesters and memory) uses master.
interface dmem_arbiter_if #(
   parameter int AW = 6
);
   // core port
   logic          c_req;
   logic          c_we;
   logic [AW-1:0] c_addr;
   logic [31:0]   c_wdata;
   logic [3:0]    c_wstrb;
   logic          c_gnt;
   logic          c_rvalid;
   logic [31:0]   c_rdata;

   // debug port
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [31:0]   d_wdata;
   logic [3:0]    d_wstrb;
   logic          d_lock;
   logic          d_gnt;
   logic          d_rvalid;
   logic [31:0]   d_rdata;

   // memory port
   logic          m_en;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [31:0]   m_wdata;
   logic [3:0]    m_wstrb;
   logic [31:0]   m_rdata;

   modport slave (
      input  c_req, c_we, c_addr, c_wdata, c_wstrb,
      output c_gnt, c_rvalid, c_rdata,
      input  d_req, d_we, d_addr, d_wdata, d_wstrb, d_lock,
      output d_gnt, d_rvalid, d_rdata,
      output m_en, m_we, m_addr, m_wdata, m_wstrb,
      input  m_rdata
   );

   modport master (
      output c_req, c_we, c_addr, c_wdata, c_wstrb,
      input  c_gnt, c_rvalid, c_rdata,
      output d_req, d_we, d_addr, d_wdata, d_wstrb, d_lock,
      input  d_gnt, d_rvalid, d_rdata,
      input  m_en, m_we, m_addr, m_wdata, m_wstrb,
      output m_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter. Core and debug share one memory port.
// ARB state: round-robin between the two ports. LOCK state: debug has
// priority for back-to-back dumps, bounded by a burst counter so that a
// waiting core is forced through after MAXBURST consecutive debug grants.
// Grants are combinational; read responses return one cycle after grant.
module dmem_arbiter #(
   parameter int AW       = 6,
   parameter int MAXBURST = 16
) (
   input  logic            clk,
   input  logic            rst,
   dmem_arbiter_if.slave   bus
);

   // counter must be able to hold MAXBURST itself
   localparam int              CW       = $clog2(MAXBURST + 1);
   localparam logic [CW-1:0]   CNT_MAX  = CW'(MAXBURST);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]   CNT_ZERO = CW'(0);

   typedef enum logic {
      ARB  = 1'b0,
      LOCK = 1'b1
   } state_t;

   state_t         state_r;
   state_t         state_s;
   logic [CW-1:0]  cnt_r;
   logic [CW-1:0]  cnt_s;
   logic           last_d_r;     // 1: debug was granted last
   logic           last_d_s;
   logic           c_rvalid_r;   // read owner: core
   logic           d_rvalid_r;   // read owner: debug
   logic           c_gnt_s;
   logic           d_gnt_s;
   logic           m_we_s;
   logic [AW-1:0]  m_addr_s;
   logic [31:0]    m_wdata_s;
   logic [3:0]     m_wstrb_s;

   // Grant decision and next state; grants are suppressed while in reset
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      last_d_s = last_d_r;
      c_gnt_s  = 1'b0;
      d_gnt_s  = 1'b0;
      if (!rst) begin
         state_s = ARB;
         cnt_s   = CNT_ZERO;
      end else begin
         case (state_r)
            ARB: begin
               if (bus.c_req && bus.d_req) begin
                  c_gnt_s = last_d_r;
                  d_gnt_s = ~last_d_r;
               end else begin
                  c_gnt_s = bus.c_req;
                  d_gnt_s = bus.d_req;
               end
               if (d_gnt_s && bus.d_lock) begin
                  state_s = LOCK;
                  cnt_s   = CNT_ONE;
               end else begin
                  state_s = ARB;
                  cnt_s   = cnt_r;
               end
            end
            LOCK: begin
               if ((cnt_r == CNT_MAX) && bus.c_req) begin
                  // forced yield to a core that has waited out the burst
                  c_gnt_s = 1'b1;
                  state_s = ARB;
                  cnt_s   = CNT_ZERO;
               end else begin
                  if (bus.d_req) begin
                     d_gnt_s = 1'b1;
                     if (cnt_r != CNT_MAX) begin
                        cnt_s = cnt_r + CNT_ONE;
                     end else begin
                        cnt_s = cnt_r;
                     end
                  end else begin
                     // work-conserving core grant, burst count untouched
                     c_gnt_s = bus.c_req;
                  end
                  if (!bus.d_lock) begin
                     state_s = ARB;
                     cnt_s   = CNT_ZERO;
                  end else begin
                     state_s = LOCK;
                  end
               end
            end
            default: begin
               state_s = ARB;
               cnt_s   = CNT_ZERO;
            end
         endcase
      end
      if (c_gnt_s) begin
         last_d_s = 1'b0;
      end else if (d_gnt_s) begin
         last_d_s = 1'b1;
      end else begin
         last_d_s = last_d_r;
      end
   end

   // Memory port mux: copy the granted requester's payload, idle otherwise
   always_comb begin
      m_we_s    = 1'b0;
      m_addr_s  = {AW{1'b0}};
      m_wdata_s = 32'h0000_0000;
      m_wstrb_s = 4'b0000;
      if (c_gnt_s) begin
         m_we_s    = bus.c_we;
         m_addr_s  = bus.c_addr;
         m_wdata_s = bus.c_wdata;
         m_wstrb_s = bus.c_wstrb;
      end else if (d_gnt_s) begin
         m_we_s    = bus.d_we;
         m_addr_s  = bus.d_addr;
         m_wdata_s = bus.d_wdata;
         m_wstrb_s = bus.d_wstrb;
      end else begin
         m_we_s    = 1'b0;
      end
   end

   // State, burst counter, last-granted and read-owner registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r    <= ARB;
         cnt_r      <= CNT_ZERO;
         last_d_r   <= 1'b1;
         c_rvalid_r <= 1'b0;
         d_rvalid_r <= 1'b0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         last_d_r   <= last_d_s;
         c_rvalid_r <= c_gnt_s & ~bus.c_we;
         d_rvalid_r <= d_gnt_s & ~bus.d_we;
      end
   end

   assign bus.c_gnt    = c_gnt_s;
   assign bus.d_gnt    = d_gnt_s;
   assign bus.c_rvalid = c_rvalid_r;
   assign bus.d_rvalid = d_rvalid_r;
   assign bus.c_rdata  = bus.m_rdata;
   assign bus.d_rdata  = bus.m_rdata;
   assign bus.m_en     = c_gnt_s | d_gnt_s;
   assign bus.m_we     = m_we_s;
   assign bus.m_addr   = m_addr_s;
   assign bus.m_wdata  = m_wdata_s;
   assign bus.m_wstrb  = m_wstrb_s;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a byte-strobed 64-word memory
// model behind the shared port.
module tb_dmem_arbiter;

   localparam int AW = 6;

   logic clk = 1'b0;
   logic rst;
   int   test_cnt = 0;
   int   fail_cnt = 0;

   logic [31:0] mem [0:63];

   dmem_arbiter_if #(.AW(AW)) bus();

   dmem_arbiter #(.AW(AW), .MAXBURST(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Memory model: strobed writes, read data one cycle after the enable
   always @(posedge clk) begin
      if (bus.m_en && bus.m_we) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.m_wstrb[b]) mem[bus.m_addr][8*b +: 8] <= bus.m_wdata[8*b +: 8];
         end
      end
      if (bus.m_en && !bus.m_we) bus.m_rdata <= mem[bus.m_addr];
   end

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      test_cnt++;
      if (obs !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_addr = 6'd0;
      bus.c_wdata = 32'h0; bus.c_wstrb = 4'b0000;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 6'd0;
      bus.d_wdata = 32'h0; bus.d_wstrb = 4'b0000; bus.d_lock = 1'b0;
   endtask

   task automatic core_drive(input logic req, input logic we, input logic [5:0] addr,
                             input logic [31:0] wdata, input logic [3:0] wstrb);
      bus.c_req = req; bus.c_we = we; bus.c_addr = addr;
      bus.c_wdata = wdata; bus.c_wstrb = wstrb;
   endtask

   task automatic dbg_drive(input logic req, input logic we, input logic [5:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb, input logic lock);
      bus.d_req = req; bus.d_we = we; bus.d_addr = addr;
      bus.d_wdata = wdata; bus.d_wstrb = wstrb; bus.d_lock = lock;
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;

      // grants held off combinationally while in reset
      core_drive(1'b1, 1'b1, 6'd1, 32'hFFFF_FFFF, 4'b1111);
      dbg_drive(1'b1, 1'b0, 6'd2, 32'h0, 4'b0000, 1'b0);
      #2;
      check_value("rst_c_gnt", 32'(bus.c_gnt), 32'd0);
      check_value("rst_d_gnt", 32'(bus.d_gnt), 32'd0);
      check_value("rst_m_en", 32'(bus.m_en), 32'd0);
      check_value("rst_m_we", 32'(bus.m_we), 32'd0);
      step();
      check_value("rst_c_rvalid", 32'(bus.c_rvalid), 32'd0);
      check_value("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
      idle_inputs();
      rst = 1'b1;
      step();

      // preload mem[5] through the core port, then read it back
      core_drive(1'b1, 1'b1, 6'd5, 32'hDEAD_BEEF, 4'b1111);
      #2;
      check_value("pre_c_gnt", 32'(bus.c_gnt), 32'd1);
      step();
      core_drive(1'b1, 1'b0, 6'd5, 32'h0, 4'b0000);
      #2;
      check_value("rd_c_gnt", 32'({bus.c_gnt, bus.d_gnt}), 32'd2);
      check_value("rd_m_en", 32'(bus.m_en), 32'd1);
      check_value("rd_m_addr", 32'(bus.m_addr), 32'd5);
      check_value("rd_m_we", 32'(bus.m_we), 32'd0);
      check_value("pre_no_rvalid", 32'(bus.c_rvalid), 32'd0);
      step();
      idle_inputs();
      #2;
      check_value("rd_c_rvalid", 32'(bus.c_rvalid), 32'd1);
      check_value("rd_c_rdata", bus.c_rdata, 32'hDEAD_BEEF);
      check_value("rd_d_rvalid", 32'(bus.d_rvalid), 32'd0);
      step();
      check_value("rd_rvalid_drop", 32'(bus.c_rvalid), 32'd0);

      // strobed write: only the low two bytes change
      core_drive(1'b1, 1'b1, 6'd3, 32'hAAAA_AAAA, 4'b1111);
      step();
      core_drive(1'b1, 1'b1, 6'd3, 32'h1234_5678, 4'b0011);
      #2;
      check_value("wr_m_we", 32'(bus.m_we), 32'd1);
      check_value("wr_m_wstrb", 32'(bus.m_wstrb), 32'd3);
      check_value("wr_m_wdata", bus.m_wdata, 32'h1234_5678);
      check_value("wr_m_addr", 32'(bus.m_addr), 32'd3);
      step();
      core_drive(1'b1, 1'b0, 6'd3, 32'h0, 4'b0000);
      #2;
      check_value("wr_no_rvalid", 32'(bus.c_rvalid), 32'd0);
      step();
      idle_inputs();
      #2;
      check_value("wr_readback_v", 32'(bus.c_rvalid), 32'd1);
      check_value("wr_readback", bus.c_rdata, 32'hAAAA_5678);

      // round robin: C, D, C, D after reset
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         core_drive(1'b1, 1'b0, 6'd5, 32'h0, 4'b0000);
         dbg_drive(1'b1, 1'b0, 6'd3, 32'h0, 4'b0000, 1'b0);
         #2;
         check_value($sformatf("rr_gnt%0d", i), 32'({bus.c_gnt, bus.d_gnt}),
                     (i % 2 == 0) ? 32'd2 : 32'd1);
         step();
         check_value($sformatf("rr_rv%0d", i), 32'({bus.c_rvalid, bus.d_rvalid}),
                     (i % 2 == 0) ? 32'd2 : 32'd1);
      end

      // locked debug burst with a core waiting from cycle 2: forced yield on the 17th
      apply_reset();
      for (int cyc = 0; cyc < 20; cyc++) begin
         dbg_drive(1'b1, 1'b0, 6'(cyc), 32'h0, 4'b0000, 1'b1);
         core_drive((cyc >= 2) ? 1'b1 : 1'b0, 1'b0, 6'd5, 32'h0, 4'b0000);
         #2;
         check_value($sformatf("burst_gnt%0d", cyc), 32'({bus.c_gnt, bus.d_gnt}),
                     (cyc == 16) ? 32'd2 : 32'd1);
         step();
         if (cyc == 15) check_value("burst_cnt_full", 32'(dut.cnt_r), 32'd16);
         if (cyc == 16) begin
            check_value("yield_state", 32'(dut.state_r), 32'd0);
            check_value("yield_cnt", 32'(dut.cnt_r), 32'd0);
         end
      end

      // core served inside LOCK, then lock release together with a debug grant
      apply_reset();
      dbg_drive(1'b1, 1'b0, 6'd1, 32'h0, 4'b0000, 1'b1);
      #2;
      check_value("lk_enter_gnt", 32'({bus.c_gnt, bus.d_gnt}), 32'd1);
      step();
      check_value("lk_state", 32'(dut.state_r), 32'd1);
      check_value("lk_cnt", 32'(dut.cnt_r), 32'd1);
      dbg_drive(1'b0, 1'b0, 6'd1, 32'h0, 4'b0000, 1'b1);
      core_drive(1'b1, 1'b0, 6'd5, 32'h0, 4'b0000);
      #2;
      check_value("lk_core_gnt", 32'({bus.c_gnt, bus.d_gnt}), 32'd2);
      step();
      check_value("lk_core_state", 32'(dut.state_r), 32'd1);
      check_value("lk_core_cnt", 32'(dut.cnt_r), 32'd1);
      check_value("lk_core_rdata", bus.c_rdata, 32'hDEAD_BEEF);
      dbg_drive(1'b1, 1'b0, 6'd1, 32'h0, 4'b0000, 1'b0);
      #2;
      check_value("unlk_gnt", 32'({bus.c_gnt, bus.d_gnt}), 32'd1);
      step();
      check_value("unlk_state", 32'(dut.state_r), 32'd0);
      check_value("unlk_cnt", 32'(dut.cnt_r), 32'd0);
      #2;
      check_value("unlk_rr_gnt", 32'({bus.c_gnt, bus.d_gnt}), 32'd2);

      // reset right after a debug read grant swallows the response
      apply_reset();
      dbg_drive(1'b1, 1'b0, 6'd5, 32'h0, 4'b0000, 1'b0);
      #2;
      check_value("rd_rst_gnt", 32'(bus.d_gnt), 32'd1);
      rst = 1'b0;
      #1;
      check_value("rd_rst_gnt_off", 32'(bus.d_gnt), 32'd0);
      step();
      check_value("rd_rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
      idle_inputs();
      rst = 1'b1;
      step();
      check_value("post_rst_state", 32'(dut.state_r), 32'd0);
      check_value("post_rst_cnt", 32'(dut.cnt_r), 32'd0);
      check_value("post_rst_rvalid", 32'({bus.c_rvalid, bus.d_rvalid}), 32'd0);
      check_value("post_rst_gnt", 32'({bus.c_gnt, bus.d_gnt}), 32'd0);
      check_value("post_rst_m_en", 32'(bus.m_en), 32'd0);
      core_drive(1'b1, 1'b0, 6'd5, 32'h0, 4'b0000);
      dbg_drive(1'b1, 1'b0, 6'd3, 32'h0, 4'b0000, 1'b0);
      #2;
      check_value("post_rst_first", 32'({bus.c_gnt, bus.d_gnt}), 32'd2);
      step();
      idle_inputs();

      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

endmodule
